multiexp_window_sched: RTL

- Front-end scheduler for the multiexp engine: buffers a batch of (point, scalar) pairs once, then replays them window by window, MSB window first.
- Each beat carries the point, a WINDOW-bit scalar digit and a core index.
- Generalises the one-bit-per-pass scheme: feeds NUM_CORES arithmetic cores for windowed/bucket accumulation.
- Removes the need for the host to re-stream the full batch every bit.

---
 rtl/multiexp_window_sched.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/multiexp_window_sched.sv
// multiexp_window_sched: buffers one batch of (point, scalar) pairs, then
// replays it window by window (MSB window first) as digit beats for the cores.
module multiexp_window_sched #(
    parameter int PNT_BITS  = 768,
    parameter int SCL_BITS  = 256,
    parameter int WINDOW    = 4,
    parameter int NUM_CORES = 16,
    parameter int MAX_IN    = 1024,
    parameter int SKIP_ZERO = 0,
    localparam int NWIN = (SCL_BITS + WINDOW - 1) / WINDOW,
    localparam int CW   = $clog2(MAX_IN + 1),
    localparam int WW   = (NWIN > 1) ? $clog2(NWIN) : 1,
    localparam int CRW  = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_start,
    input  logic [CW-1:0]                i_num_in,
    input  logic                         i_val,
    output logic                         o_rdy,
    input  logic [PNT_BITS+SCL_BITS-1:0] i_dat,
    output logic                         o_val,
    input  logic                         i_rdy,
    output logic [PNT_BITS-1:0]          o_pnt,
    output logic [WINDOW-1:0]            o_dig,
    output logic [CRW-1:0]               o_core,
    output logic [WW-1:0]                o_win,
    output logic                         o_sop,
    output logic                         o_eop,
    output logic                         o_busy,
    output logic                         o_done,
    output logic                         o_err
);

    localparam int AW   = (MAX_IN > 1) ? $clog2(MAX_IN) : 1;
    localparam int DW   = PNT_BITS + SCL_BITS;
    localparam int PADW = NWIN * WINDOW;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_EMIT, S_DONE} state_t;

    state_t          r_state;
    logic [DW-1:0]   r_mem [MAX_IN];
    logic [DW-1:0]   r_rd_q;
    logic [CW-1:0]   r_n;
    logic            r_err;
    logic [AW-1:0]   r_wr_idx;
    logic [AW-1:0]   r_rd_idx;
    logic [WW-1:0]   r_rd_win;
    logic            r_rd_act;
    logic [AW-1:0]   r_s1_idx;
    logic [WW-1:0]   r_s1_win;
    logic            r_s1_vld;
    logic [CRW-1:0]  r_cnt;
    logic            r_pend_sop;

    logic            w_out_adv;
    logic            w_s1_adv;
    logic            w_issue;
    logic            w_wr;
    logic            w_s1_last;
    logic            w_s1_first;
    logic            w_rd_last;
    logic [PADW-1:0] w_scl_pad;
    logic [WINDOW-1:0] w_dig;
    logic            w_emit;
    logic [CRW-1:0]  w_cnt;
    logic            w_sop;
    logic [CW-1:0]   w_n_req;

    // Pipeline: read issue -> RAM data (s1) -> output register
    assign w_out_adv  = !o_val || i_rdy;
    assign w_s1_adv   = !r_s1_vld || w_out_adv;
    assign w_issue    = (r_state == S_EMIT) && r_rd_act && w_s1_adv;
    assign w_wr       = (r_state == S_LOAD) && o_rdy && i_val;
    assign w_s1_last  = CW'(r_s1_idx) == (r_n - CW'(1));
    assign w_s1_first = r_s1_idx == '0;
    assign w_rd_last  = CW'(r_rd_idx) == (r_n - CW'(1));
    assign w_scl_pad  = PADW'(r_rd_q[SCL_BITS-1:0]);
    assign w_dig      = w_scl_pad[int'(r_s1_win)*WINDOW +: WINDOW];
    assign w_emit     = (SKIP_ZERO == 0) || (w_dig != '0) || w_s1_last;
    assign w_cnt      = w_s1_first ? '0 : r_cnt;
    assign w_sop      = w_s1_first || r_pend_sop;
    assign w_n_req    = (i_num_in > CW'(MAX_IN)) ? CW'(MAX_IN) : i_num_in;

    // Pair buffer: written during LOAD, prefetch-read during EMIT
    always_ff @(posedge i_clk) begin
        if (w_wr)
            r_mem[r_wr_idx] <= i_dat;
        if (w_issue)
            r_rd_q <= r_mem[r_rd_idx];
    end

    // Batch FSM with read iterator, digit stage and registered outputs
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_n        <= '0;
            r_err      <= 1'b0;
            r_wr_idx   <= '0;
            r_rd_idx   <= '0;
            r_rd_win   <= '0;
            r_rd_act   <= 1'b0;
            r_s1_idx   <= '0;
            r_s1_win   <= '0;
            r_s1_vld   <= 1'b0;
            r_cnt      <= '0;
            r_pend_sop <= 1'b0;
            o_rdy      <= 1'b0;
            o_val      <= 1'b0;
            o_pnt      <= '0;
            o_dig      <= '0;
            o_core     <= '0;
            o_win      <= '0;
            o_sop      <= 1'b0;
            o_eop      <= 1'b0;
            o_busy     <= 1'b0;
            o_done     <= 1'b0;
            o_err      <= 1'b0;
        end else begin
            o_done <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_n      <= w_n_req;
                        r_err    <= i_num_in > CW'(MAX_IN);
                        r_wr_idx <= '0;
                        o_busy   <= 1'b1;
                        if (i_num_in == '0) begin
                            r_state <= S_DONE;
                            o_done  <= 1'b1;
                            o_err   <= 1'b0;
                        end else begin
                            r_state <= S_LOAD;
                            o_rdy   <= 1'b1;
                        end
                    end
                end
                S_LOAD: begin
                    if (w_wr) begin
                        r_wr_idx <= r_wr_idx + AW'(1);
                        if (CW'(r_wr_idx) == (r_n - CW'(1))) begin
                            o_rdy      <= 1'b0;
                            r_state    <= S_EMIT;
                            r_rd_idx   <= '0;
                            r_rd_win   <= WW'(NWIN - 1);
                            r_rd_act   <= 1'b1;
                            r_s1_vld   <= 1'b0;
                            r_cnt      <= '0;
                            r_pend_sop <= 1'b0;
                        end
                    end
                end
                S_EMIT: begin
                    if (w_s1_adv) begin
                        r_s1_vld <= w_issue;
                        r_s1_idx <= r_rd_idx;
                        r_s1_win <= r_rd_win;
                    end
                    if (w_issue) begin
                        if (w_rd_last) begin
                            r_rd_idx <= '0;
                            if (r_rd_win == '0)
                                r_rd_act <= 1'b0;
                            else
                                r_rd_win <= r_rd_win - WW'(1);
                        end else begin
                            r_rd_idx <= r_rd_idx + AW'(1);
                        end
                    end
                    if (w_out_adv) begin
                        if (r_s1_vld && w_emit) begin
                            o_val      <= 1'b1;
                            o_pnt      <= r_rd_q[SCL_BITS +: PNT_BITS];
                            o_dig      <= w_dig;
                            o_core     <= w_cnt;
                            o_win      <= r_s1_win;
                            o_sop      <= w_sop;
                            o_eop      <= w_s1_last;
                            r_cnt      <= (NUM_CORES == 1) ? '0 : w_cnt + CRW'(1);
                            r_pend_sop <= 1'b0;
                        end else begin
                            o_val <= 1'b0;
                            o_sop <= 1'b0;
                            o_eop <= 1'b0;
                            if (r_s1_vld) begin
                                r_cnt      <= w_cnt;
                                r_pend_sop <= w_sop;
                            end
                        end
                    end
                    if (o_val && i_rdy && o_eop && (o_win == '0)) begin
                        r_state <= S_DONE;
                        o_done  <= 1'b1;
                        o_err   <= r_err;
                        o_val   <= 1'b0;
                        o_sop   <= 1'b0;
                        o_eop   <= 1'b0;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    o_busy  <= 1'b0;
                    o_err   <= 1'b0;
                end
            endcase
        end
    end

endmodule
